// File: rtl/instr_encoder.sv
// RISC-V instruction encoder: turns decoded instruction fields into 32-bit words
// and streams them into instruction memory at an auto-incrementing address.
module instr_encoder #(
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_class,
  input  logic [2:0]              in_funct3,
  input  logic                    in_alt,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [31:0]             in_imm,
  input  logic                    load_addr,
  input  logic [ADDRESS_BITS-1:0] start_addr,
  output logic                    mem_wEn,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [31:0]             mem_wdata,
  output logic                    error,
  output logic [15:0]             word_count
);

  typedef enum logic [1:0] {IDLE, EMIT, EMIT2, ERR} state_e;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_IALU   = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_LI     = 4'd9
  } class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_e                  state, state_d;
  logic [31:0]             word0_q, word1_q;
  logic                    two_q;
  logic [31:0]             enc_word0, enc_word1;
  logic                    enc_two, enc_bad;
  logic                    accept, wr_en;
  logic [ADDRESS_BITS-1:0] counter;
  logic                    li_fits;
  logic [19:0]             li_hi;

  assign accept  = in_valid && in_ready;
  // A value fits a 12-bit signed immediate when bits [31:11] are a pure sign extension.
  assign li_fits = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  // Rounding the upper part by imm[11] compensates for the sign-extended ADDI that follows.
  assign li_hi   = in_imm[31:12] + {19'd0, in_imm[11]};

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    enc_word0 = '0;
    enc_word1 = '0;
    enc_two   = 1'b0;
    enc_bad   = 1'b0;
    case (class_e'(in_class))
      CLS_R:      enc_word0 = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      CLS_IALU: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc_word0 = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_I};
        else
          enc_word0 = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
      end
      CLS_LOAD:   enc_word0 = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      CLS_STORE:  enc_word0 = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      CLS_BRANCH: begin
        enc_word0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
        enc_bad   = in_imm[0];
      end
      CLS_JAL: begin
        enc_word0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        enc_bad   = in_imm[0];
      end
      CLS_JALR:   enc_word0 = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      CLS_LUI:    enc_word0 = {in_imm[19:0], in_rd, OP_LUI};
      CLS_AUIPC:  enc_word0 = {in_imm[19:0], in_rd, OP_AUIPC};
      CLS_LI: begin
        if (li_fits) begin
          enc_word0 = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_I};
        end else begin
          enc_word0 = {li_hi, in_rd, OP_LUI};
          enc_word1 = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_I};
          enc_two   = |in_imm[11:0];
        end
      end
      default:    enc_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = enc_bad ? ERR : EMIT;
      EMIT:    state_d = two_q ? EMIT2 : IDLE;
      EMIT2:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: the captured words need no reset; they are only observed in EMIT/EMIT2,
  // which can only be reached through a fresh acceptance.
  always_ff @(posedge clock) begin
    if (accept) begin
      word0_q <= enc_word0;
      word1_q <= enc_word1;
      two_q   <= enc_two;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter    <= '0;
      word_count <= '0;
    end else begin
      if (load_addr)  counter <= start_addr;
      else if (wr_en) counter <= counter + ADDRESS_BITS'(4);
      if (wr_en) word_count <= word_count + 16'd1;
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    wr_en     = (state == EMIT) || (state == EMIT2);
    error     = (state == ERR);
    mem_wEn   = wr_en;
    mem_addr  = wr_en ? counter : '0;
    mem_wdata = '0;
    if (state == EMIT)       mem_wdata = word0_q;
    else if (state == EMIT2) mem_wdata = word1_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors with literal expectations,
// then randomized requests predicted by an arithmetic field-placement model.
module tb_instr_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_class = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        load_addr = 1'b0;
  logic [15:0] start_addr = '0;
  logic        mem_wEn;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        error;
  logic [15:0] word_count;

  instr_encoder #(.ADDRESS_BITS(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .load_addr(load_addr),
    .start_addr(start_addr), .mem_wEn(mem_wEn), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .error(error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_err;
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_addr = '0;
  int          m_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint fld(input logic [31:0] v, input int hi, input int lo);
    return (longint'({32'd0, v}) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  // Generic six-field layout: op | a<<7 | f3<<12 | rs1<<15 | b<<20 | top<<25.
  function automatic logic [31:0] rtype(input longint op, a, f3, rs1, b, top);
    return 32'(op + (a << 7) + (f3 << 12) + (rs1 << 15) + (b << 20) + (top << 25));
  endfunction

  function automatic logic [31:0] itype(input longint op, rd, f3, rs1, imm12);
    return rtype(op, rd, f3, rs1, imm12 % 32, imm12 / 32);
  endfunction

  function automatic void ref_encode(input int cls, f3, alt, rd, rs1, rs2,
                                     input logic [31:0] imm, output bit bad, output int n,
                                     output logic [31:0] w0, output logic [31:0] w1);
    longint jf, hi;
    int simm;
    bad = 0; n = 1; w0 = '0; w1 = '0;
    case (cls)
      0: w0 = rtype(51, rd, f3, rs1, rs2, alt * 32);
      1: begin
        if (f3 == 1 || f3 == 5) w0 = itype(19, rd, f3, rs1, alt * 1024 + fld(imm, 4, 0));
        else                    w0 = itype(19, rd, f3, rs1, fld(imm, 11, 0));
      end
      2: w0 = itype(3, rd, f3, rs1, fld(imm, 11, 0));
      3: w0 = rtype(35, fld(imm, 4, 0), f3, rs1, rs2, fld(imm, 11, 5));
      4: begin
        bad = imm[0];
        w0 = rtype(99, fld(imm, 4, 1) * 2 + fld(imm, 11, 11), f3, rs1, rs2,
                   fld(imm, 12, 12) * 64 + fld(imm, 10, 5));
      end
      5: begin
        bad = imm[0];
        jf = fld(imm, 20, 20) * 524288 + fld(imm, 10, 1) * 512 + fld(imm, 11, 11) * 256
             + fld(imm, 19, 12);
        w0 = 32'(111 + longint'(rd) * 128 + jf * 4096);
      end
      6: w0 = itype(103, rd, 0, rs1, fld(imm, 11, 0));
      7: w0 = 32'(55 + longint'(rd) * 128 + fld(imm, 19, 0) * 4096);
      8: w0 = 32'(23 + longint'(rd) * 128 + fld(imm, 19, 0) * 4096);
      9: begin
        simm = int'(imm);
        if (simm >= -2048 && simm <= 2047) begin
          w0 = itype(19, rd, 0, 0, fld(imm, 11, 0));
        end else begin
          hi = fld(imm + 32'h800, 31, 12);
          w0 = 32'(55 + longint'(rd) * 128 + hi * 4096);
          if (fld(imm, 11, 0) != 0) begin
            n = 2;
            w1 = itype(19, rd, 0, rd, fld(imm, 11, 0));
          end
        end
      end
      default: bad = 1;
    endcase
    if (bad) n = 0;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic expect_write_at(input logic [15:0] addr, input logic [31:0] data);
    exp_q.push_back('{is_err: 1'b0, addr: addr, data: data});
    m_addr = addr + 16'd4;
    m_count++;
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, addr: 16'd0, data: 32'd0});
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic drive(input int cls, f3, alt, rd, rs1, rs2, input logic [31:0] imm,
                       input bit do_load, input logic [15:0] ld);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clock); #1; waited++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    if (!in_ready) return;
    in_class = 4'(cls); in_funct3 = 3'(f3); in_alt = 1'(alt);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
    load_addr = do_load; start_addr = ld; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; load_addr = 1'b0;
  endtask

  task automatic issue_model(input int cls, f3, alt, rd, rs1, rs2, input logic [31:0] imm,
                             input bit do_load, input logic [15:0] ld);
    bit bad; int n; logic [31:0] w0, w1;
    if (do_load) m_addr = ld;
    ref_encode(cls, f3, alt, rd, rs1, rs2, imm, bad, n, w0, w1);
    if (bad) expect_err();
    if (n >= 1) expect_write_at(m_addr, w0);
    if (n == 2) expect_write_at(m_addr, w1);
    drive(cls, f3, alt, rd, rs1, rs2, imm, do_load, ld);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 100) begin
      @(posedge clock); #1; t++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
    check("word_count", 32'(word_count), 32'(16'(m_count)));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (mem_wEn || error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, mem_wEn, error}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) begin
            check("error_pulse", {30'd0, mem_wEn, error}, 32'd1);
          end else begin
            check("write_strobe", {30'd0, mem_wEn, error}, 32'd2);
            check("write_addr", 32'(mem_addr), 32'(e.addr));
            check("write_data", mem_wdata, e.data);
          end
        end
      end else begin
        check("idle_addr_zero", 32'(mem_addr), 32'd0);
        check("idle_data_zero", mem_wdata, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] bnd [6];
    logic [31:0] imm;
    int cls;
    bnd[0] = 32'h0000_07FF; bnd[1] = 32'h0000_0800; bnd[2] = 32'hFFFF_F800;
    bnd[3] = 32'hFFFF_F7FF; bnd[4] = 32'h7FFF_F800; bnd[5] = 32'hFFFF_FFFF;

    #2;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_wen", 32'(mem_wEn), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_wcount", 32'(word_count), 32'd0);
    @(negedge clock); #2 reset = 1'b1;
    @(posedge clock); #1;

    // R-type, alt clear then set; second request waits out the EMIT cycle
    expect_write_at(16'h0000, 32'h0020_81B3);
    drive(0, 0, 0, 3, 1, 2, 32'd0, 0, 16'd0);
    check("ready_low_emit", 32'(in_ready), 32'd0);
    expect_write_at(16'h0004, 32'h4020_81B3);
    drive(0, 0, 1, 3, 1, 2, 32'd0, 0, 16'd0);
    drain();

    // LI needing LUI+ADDI; in_ready low for exactly two cycles
    expect_write_at(16'h0008, 32'h1234_52B7);
    expect_write_at(16'h000C, 32'h6782_8293);
    drive(9, 0, 0, 5, 0, 0, 32'h1234_5678, 0, 16'd0);
    check("li_ready_emit", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    check("li_ready_emit2", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    check("li_ready_back", 32'(in_ready), 32'd1);
    drain();

    expect_write_at(16'h0010, 32'h0000_10B7);
    expect_write_at(16'h0014, 32'h8000_8093);
    drive(9, 0, 0, 1, 0, 0, 32'h0000_0800, 0, 16'd0);
    drain();

    expect_write_at(16'h0018, 32'hFE20_8EE3);
    drive(4, 0, 0, 0, 1, 2, 32'hFFFF_FFFC, 0, 16'd0);
    drain();

    // misaligned JAL: one-cycle error, no write, counter untouched
    expect_err();
    drive(5, 0, 0, 1, 0, 0, 32'd3, 0, 16'd0);
    check("err_pulse", 32'(error), 32'd1);
    check("err_no_write", 32'(mem_wEn), 32'd0);
    @(posedge clock); #1;
    check("err_one_cycle", 32'(error), 32'd0);
    drain();
    expect_write_at(16'h001C, 32'h0020_81B3);
    drive(0, 0, 0, 3, 1, 2, 32'd0, 0, 16'd0);
    drain();

    // load during EMIT: current write keeps old address, load beats increment
    expect_write_at(16'h0020, 32'h0020_81B3);
    drive(0, 0, 0, 3, 1, 2, 32'd0, 0, 16'd0);
    load_addr = 1'b1; start_addr = 16'h1000;
    @(posedge clock); #1;
    load_addr = 1'b0;
    expect_write_at(16'h1000, 32'h4020_81B3);
    drive(0, 0, 1, 3, 1, 2, 32'd0, 0, 16'd0);
    drain();

    // load with acceptance at the top of the space, then wrap
    expect_write_at(16'hFFFC, 32'h0020_81B3);
    drive(0, 0, 0, 3, 1, 2, 32'd0, 1, 16'hFFFC);
    expect_write_at(16'h0000, 32'h4020_81B3);
    drive(0, 0, 1, 3, 1, 2, 32'd0, 0, 16'd0);
    drain();

    // randomized requests against the model
    for (int i = 0; i < 300; i++) begin
      cls = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        2: imm = $urandom & 32'hFFFF_F000;
        3: imm = bnd[$urandom_range(0, 5)];
        default: imm = $urandom & 32'hFFFF_FFFE;
      endcase
      if ($urandom_range(0, 15) == 0)
        issue_model(cls, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), imm, 1, 16'($urandom_range(0, 65535)));
      else
        issue_model(cls, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), imm, 0, 16'd0);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    drain();

    // reset during EMIT2 of a two-word LI: second word must never appear
    expect_write_at(m_addr, 32'h1234_52B7);
    drive(9, 0, 0, 5, 0, 0, 32'h1234_5678, 0, 16'd0);
    @(posedge clock); #1;
    check("emit2_active", 32'(mem_wEn), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_emit2_wen", 32'(mem_wEn), 32'd0);
    check("rst_emit2_addr", 32'(mem_addr), 32'd0);
    check("rst_emit2_ready", 32'(in_ready), 32'd1);
    check("rst_emit2_wcount", 32'(word_count), 32'd0);
    check("rst_emit2_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clock); #2 reset = 1'b1;
    m_addr = 16'h0000; m_count = 0;
    @(posedge clock); #1;
    expect_write_at(16'h0000, 32'h0020_81B3);
    drive(0, 0, 0, 3, 1, 2, 32'd0, 0, 16'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 16, the instruction-memory address width.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the instruction fields are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the encoder accepts fields this cycle.
REQ-006 SHALL have port in_class, input, 4 bits: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 LI (pseudo); 10-15 invalid.
REQ-007 SHALL have port in_funct3, input, 3 bits: the funct3 field.
REQ-008 SHALL have port in_alt, input, 1 bit: sets instruction bit 30 (SUB/SRA/SRAI).
REQ-009 SHALL have ports in_rd, in_rs1 and in_rs2, inputs, 5 bits each: the register specifiers.
REQ-010 SHALL have port in_imm, input, 32 bits: the byte-offset immediate; for LUI/AUIPC, in_imm[19:0] is the upper-20 field.
REQ-011 SHALL have ports load_addr (input, 1 bit) and start_addr (input, ADDRESS_BITS): load_addr loads the write-address counter from start_addr.
REQ-012 SHALL have ports mem_wEn (output, 1 bit), mem_addr (output, ADDRESS_BITS) and mem_wdata (output, 32 bits): the instruction-memory write port.
REQ-013 SHALL have port error, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-014 SHALL have port word_count, output, 16 bits: count of words written, wrapping modulo 2^16.

Function
REQ-015 SHALL implement the states IDLE, EMIT, EMIT2 and ERR; in_ready SHALL be 1 only in IDLE.
REQ-016 SHALL, on in_valid&in_ready, register all fields and go to EMIT, or to ERR if the class is invalid or a BRANCH/JAL has in_imm[0]=1.
REQ-017 SHALL, in EMIT, drive mem_wEn=1 for exactly one cycle with mem_addr = counter and mem_wdata = the encoded word, then counter += 4 and word_count += 1.
REQ-018 SHALL give a latency of one cycle (fields accepted at edge N, write visible in cycle N+1) and a throughput of one request per 2 cycles (3 for a two-word LI).
REQ-019 SHALL use opcodes R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111 (funct3 000), LUI 0110111 and AUIPC 0010111.
REQ-020 SHALL place the immediate fields as follows:
- I: imm[11:0]→[31:20].
- S: imm[11:5]→[31:25], imm[4:0]→[11:7].
- B: imm[12|10:5]→[31|30:25], imm[4:1|11]→[11:8|7].
- U: in_imm[19:0]→[31:12].
- J: imm[20|10:1|11|19:12]→[31|30:21|20|19:12].
REQ-021 SHALL, for I-ALU with funct3 001/101, force [31:25]={0,in_alt,00000} and [24:20]=imm[4:0]; for R-type, bit 30=in_alt and the other funct7 bits are 0.
REQ-022 SHALL, for LI with -2048≤imm≤2047, emit the single word ADDI rd,x0,imm.
REQ-023 SHALL otherwise emit LUI rd,hi then ADDI rd,rd,imm[11:0] (in EMIT2), where hi=(imm+0x800)>>12 truncated to 20 bits; if imm[11:0]=0, only the LUI is emitted.
REQ-024 SHALL, in ERR, pulse error=1 with mem_wEn=0, leave the counter and word_count unchanged, and return to IDLE.
REQ-025 SHALL wrap the counter modulo 2^ADDRESS_BITS (0xFFFC+4→0x0000).
REQ-026 SHALL honour load_addr in any state, and load SHALL take priority over increment; a write in the same cycle uses the old address.
REQ-027 SHALL, on load_addr together with acceptance in IDLE, write the accepted word at start_addr.
REQ-028 SHALL drive mem_addr and mem_wdata to 0 whenever mem_wEn=0.

Reset
REQ-029 SHALL, while reset=0, immediately force state IDLE, counter 0, word_count 0, mem_wEn 0, mem_addr 0, mem_wdata 0, error 0, and in_ready 1.
REQ-030 SHALL abandon any in-progress request on reset, including in EMIT2, so that no pending word is ever written.

Verification
REQ-031 SHALL cover: R, funct3 000, rd3, rs1 1, rs2 2, alt 0 → write 0x002081B3 at 0x0000; the same with alt 1 → 0x402081B3 at 0x0004.
REQ-032 SHALL cover: LI rd5, imm 0x12345678 → 0x123452B7 at 0x0000, then 0x67828293 at 0x0004; word_count=2; in_ready low for 2 cycles.
REQ-033 SHALL cover: LI rd1, imm 0x00000800 → 0x000010B7, then 0x80008093.
REQ-034 SHALL cover: BRANCH funct3 000, rs1 1, rs2 2, imm 0xFFFFFFFC → 0xFE208EE3; JAL with imm 3 → error pulse, no write, counter unchanged.
REQ-035 SHALL cover: load_addr with start_addr 0xFFFC, then two R requests → writes at 0xFFFC, then 0x0000.
REQ-036 SHALL cover: reset asserted during EMIT2 of an LI → mem_wEn drops at once, second word never written, counter 0 after release.
